// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, pixel field widths, arbiter state codes and requester ids.
package pong_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;
  localparam int DEF_COLOUR_W = 3;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;
  localparam int REQ_CLEAR = 0;
  localparam int REQ_LPAD = 1;
  localparam int REQ_RPAD = 2;
  localparam int REQ_BALL = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot winner; index 0 always wins, otherwise round-robin over 1..N-1 from ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win
);
  logic [PTR_W-1:0] idx;
  // scan from farthest to nearest so the entry nearest ptr is the last one written
  always_comb begin
    win = '0;
    idx = '0;
    if (req[0]) win[0] = 1'b1;
    else
      for (int k = N - 2; k >= 0; k--) begin
        idx = PTR_W'((int'(ptr) + N - 2 + k) % (N - 1) + 1);
        if (req[idx]) begin
          win = '0;
          win[idx] = 1'b1;
        end
      end
  end
endmodule

// File: rtl/plot_port_arbiter.sv
// plot_port_arbiter: burst-granting arbiter for the single vga_adapter pixel write port.
module plot_port_arbiter
  import pong_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int MAX_BURST = 256
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           valid,
  input  logic [NUM_REQ-1:0]           last,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           pix_ack,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  logic [0:0] state;
  logic [PTR_W-1:0] rr_ptr, win_idx, next_ptr;
  logic [15:0] burst_cnt;
  logic [NUM_REQ-1:0] win;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  logic acc, ack_last, abandon, done;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (.req(req), .ptr(rr_ptr), .win(win));

  assign pix_ack = grant & req & valid;
  assign acc = |pix_ack;
  assign ack_last = |(pix_ack & last);
  assign abandon = |(grant & ~req);
  assign done = (acc && (ack_last || burst_cnt == 16'(MAX_BURST - 1))) || abandon;
  assign busy = state == ARB_BURST;
  assign next_ptr = (int'(win_idx) == NUM_REQ - 1) ? PTR_W'(1) : win_idx + PTR_W'(1);

  always_comb begin
    win_idx = '0;
    sel_x = '0;
    sel_y = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
      if (pix_ack[i]) begin
        sel_x = req_x[i*X_W +: X_W];
        sel_y = req_y[i*Y_W +: Y_W];
        sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      grant <= '0;
      rr_ptr <= PTR_W'(1);
      burst_cnt <= '0;
      plot <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
    end else begin
      plot <= acc;
      if (acc) begin
        x <= sel_x;
        y <= sel_y;
        colour <= sel_colour;
      end
      if (state == ARB_IDLE) begin
        if (|req) begin
          state <= ARB_BURST;
          grant <= win;
          burst_cnt <= '0;
          if (!win[0]) rr_ptr <= next_ptr;
        end
      end else if (done) begin
        state <= ARB_IDLE;
        grant <= '0;
      end else if (acc) burst_cnt <= burst_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_plot_port_arbiter.sv
// tb_plot_port_arbiter: vector table, corner-case sequences and a randomized reference-model run.
module tb_plot_port_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic resetn;
  logic [3:0] req, valid, last, grant, pix_ack;
  logic [35:0] req_x;
  logic [31:0] req_y;
  logic [11:0] req_colour;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic plot, busy;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  plot_port_arbiter #(.NUM_REQ(4), .X_W(9), .Y_W(8), .COLOUR_W(3), .MAX_BURST(MB)) dut (
    .clk(clk), .resetn(resetn), .req(req), .valid(valid), .last(last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .pix_ack(pix_ack), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  typedef struct {
    logic rst;
    logic [3:0] r, v, l;
    logic [8:0] vx;
    logic [7:0] vy;
    logic [2:0] vc;
    logic [3:0] e_ack, e_grant;
    logic e_plot;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [2:0] e_c;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input logic [3:0] r, v, l, input logic [8:0] vx, input logic [7:0] vy, input logic [2:0] vc);
    req = r;
    valid = v;
    last = l;
    req_x = {4{vx}};
    req_y = {4{vy}};
    req_colour = {4{vc}};
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 9'd0, 8'd0, 3'd0);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xyc", {x, y, colour}, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic cyc(input logic [3:0] r, v, l, input logic [8:0] vx, input logic [7:0] vy, input logic [2:0] vc,
                     input logic [3:0] e_ack, e_grant, input logic e_plot, input logic [8:0] e_x,
                     input logic [7:0] e_y, input logic [2:0] e_c, input string nm);
    drive(r, v, l, vx, vy, vc);
    #1;
    chk({nm, "_ack"}, pix_ack, e_ack);
    @(posedge clk);
    #1;
    chk({nm, "_grant"}, grant, e_grant);
    chk({nm, "_plot"}, plot, e_plot);
    chk({nm, "_xyc"}, {x, y, colour}, {e_x, e_y, e_c});
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    if (r[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      int i = (p - 1 + k) % 3 + 1;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int g, cnt, ptr;
    logic mp;
    logic [8:0] mx;
    logic [7:0] my;
    logic [2:0] mc;
    logic [3:0] rq, vl, ls, ea;
    tbl[0]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 9'd0,  8'd0,  3'd0, 4'b0000, 4'b0100, 1'b0, 9'd0,  8'd0,  3'd0};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 9'd10, 8'd20, 3'd3, 4'b0100, 4'b0100, 1'b1, 9'd10, 8'd20, 3'd3};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 9'd11, 8'd20, 3'd3, 4'b0100, 4'b0100, 1'b1, 9'd11, 8'd20, 3'd3};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 9'd12, 8'd20, 3'd3, 4'b0100, 4'b0000, 1'b1, 9'd12, 8'd20, 3'd3};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 9'd0,  8'd0,  3'd0, 4'b0000, 4'b0000, 1'b0, 9'd12, 8'd20, 3'd3};
    tbl[5]  = '{1'b1, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0000, 4'b0010, 1'b0, 9'd0,  8'd0,  3'd0};
    tbl[6]  = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0010, 4'b0000, 1'b1, 9'd5,  8'd6,  3'd2};
    tbl[7]  = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0000, 4'b0100, 1'b0, 9'd5,  8'd6,  3'd2};
    tbl[8]  = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0100, 4'b0000, 1'b1, 9'd5,  8'd6,  3'd2};
    tbl[9]  = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0000, 4'b1000, 1'b0, 9'd5,  8'd6,  3'd2};
    tbl[10] = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b1000, 4'b0000, 1'b1, 9'd5,  8'd6,  3'd2};
    tbl[11] = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 9'd5,  8'd6,  3'd2, 4'b0000, 4'b0010, 1'b0, 9'd5,  8'd6,  3'd2};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].vx, tbl[i].vy, tbl[i].vc, tbl[i].e_ack, tbl[i].e_grant,
          tbl[i].e_plot, tbl[i].e_x, tbl[i].e_y, tbl[i].e_c, $sformatf("vec%0d", i));
    end
    // priority requester wins from idle but never pre-empts a running burst
    do_reset();
    cyc(4'b0011, 4'b0000, 4'b0000, 9'd0,  8'd0, 3'd0, 4'b0000, 4'b0001, 1'b0, 9'd0,  8'd0, 3'd0, "pri_first");
    cyc(4'b0011, 4'b0001, 4'b0001, 9'd7,  8'd8, 3'd1, 4'b0001, 4'b0000, 1'b1, 9'd7,  8'd8, 3'd1, "pri_pix");
    cyc(4'b0010, 4'b0000, 4'b0000, 9'd0,  8'd0, 3'd0, 4'b0000, 4'b0010, 1'b0, 9'd7,  8'd8, 3'd1, "r1_grant");
    cyc(4'b0011, 4'b0010, 4'b0000, 9'd9,  8'd8, 3'd2, 4'b0010, 4'b0010, 1'b1, 9'd9,  8'd8, 3'd2, "no_preempt");
    cyc(4'b0011, 4'b0010, 4'b0010, 9'd10, 8'd8, 3'd2, 4'b0010, 4'b0000, 1'b1, 9'd10, 8'd8, 3'd2, "r1_last");
    cyc(4'b0011, 4'b0000, 4'b0000, 9'd0,  8'd0, 3'd0, 4'b0000, 4'b0001, 1'b0, 9'd10, 8'd8, 3'd2, "pri_next");
    // forced release after MB accepted pixels, then lossless resume
    do_reset();
    cyc(4'b0100, 4'b0100, 4'b0000, 9'd100, 8'd1, 3'd5, 4'b0000, 4'b0100, 1'b0, 9'd0, 8'd0, 3'd0, "mb_grant");
    for (int k = 0; k < MB; k++)
      cyc(4'b0100, 4'b0100, 4'b0000, 9'(100 + k), 8'd1, 3'd5, 4'b0100, (k == MB - 1) ? 4'b0000 : 4'b0100,
          1'b1, 9'(100 + k), 8'd1, 3'd5, $sformatf("mb_pix%0d", k));
    cyc(4'b0100, 4'b0100, 4'b0000, 9'd104, 8'd1, 3'd5, 4'b0000, 4'b0100, 1'b0, 9'd103, 8'd1, 3'd5, "mb_idle");
    cyc(4'b0100, 4'b0100, 4'b0000, 9'd104, 8'd1, 3'd5, 4'b0100, 4'b0100, 1'b1, 9'd104, 8'd1, 3'd5, "mb_resume");
    // ungranted valid and abandoned burst
    do_reset();
    cyc(4'b0010, 4'b0000, 4'b0000, 9'd0, 8'd0, 3'd0, 4'b0000, 4'b0010, 1'b0, 9'd0, 8'd0, 3'd0, "ab_grant");
    cyc(4'b1010, 4'b1000, 4'b1000, 9'd3, 8'd3, 3'd3, 4'b0000, 4'b0010, 1'b0, 9'd0, 8'd0, 3'd0, "ungranted");
    cyc(4'b1000, 4'b1010, 4'b0000, 9'd4, 8'd4, 3'd4, 4'b0000, 4'b0000, 1'b0, 9'd0, 8'd0, 3'd0, "abandon");
    cyc(4'b0000, 4'b1000, 4'b1000, 9'd5, 8'd5, 3'd5, 4'b0000, 4'b0000, 1'b0, 9'd0, 8'd0, 3'd0, "ab_idle");
    // asynchronous reset while plotting, then pointer back at requester 1
    do_reset();
    cyc(4'b0100, 4'b0000, 4'b0000, 9'd0,  8'd0,  3'd0, 4'b0000, 4'b0100, 1'b0, 9'd0,  8'd0,  3'd0, "ar_grant");
    cyc(4'b0100, 4'b0100, 4'b0000, 9'd50, 8'd60, 3'd7, 4'b0100, 4'b0100, 1'b1, 9'd50, 8'd60, 3'd7, "ar_pix");
    #2;
    do_reset();
    cyc(4'b1110, 4'b0000, 4'b0000, 9'd0, 8'd0, 3'd0, 4'b0000, 4'b0010, 1'b0, 9'd0, 8'd0, 3'd0, "ar_rr_ptr");
    // randomized run against a behavioural model
    do_reset();
    g = -1;
    cnt = 0;
    ptr = 1;
    mx = '0;
    my = '0;
    mc = '0;
    rq = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      vl = 4'($urandom);
      ls = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      req = rq;
      valid = vl;
      last = ls;
      req_x = 36'({$urandom, $urandom});
      req_y = 32'($urandom);
      req_colour = 12'($urandom);
      #1;
      ea = (g >= 0 && rq[g] && vl[g]) ? 4'(1 << g) : 4'b0;
      chk("rnd_ack", pix_ack, ea);
      mp = ea != 0;
      if (mp) begin
        mx = req_x[g*9 +: 9];
        my = req_y[g*8 +: 8];
        mc = req_colour[g*3 +: 3];
      end
      if (g < 0) begin
        if (rq != 0) begin
          g = pick(rq, ptr);
          if (g > 0) ptr = (g == 3) ? 1 : g + 1;
          cnt = 0;
        end
      end else if ((mp && (ls[g] || cnt == MB - 1)) || !rq[g]) g = -1;
      else if (mp) cnt++;
      @(posedge clk);
      #1;
      chk("rnd_grant", grant, (g >= 0) ? 4'(1 << g) : 4'b0);
      chk("rnd_plot", plot, mp);
      chk("rnd_xyc", {x, y, colour}, {mx, my, mc});
      chk("rnd_busy", busy, g >= 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
